mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data RAM between the CPU fetch port (requester I) and the memory-stage load/store port (requester D).
- Serialises accesses through a small FSM and hides the fixed RAM read latency.
- Returns read data with a one-cycle ack pulse and drives a stall to the pipeline while any request is outstanding.
- Sits between the CPU core and the RAM, so the core can move from separate instruction/data memories to one shared memory.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported RAM between the fetch port (I) and the load/store port (D).
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          stall
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_I, G_D} grant_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY);

  state_t     r_state;
  state_t     w_state_next;
  grant_t     r_grant;
  grant_t     w_win;
  logic [3:0] r_cnt;
  logic       r_we;
  logic       w_last;

`ifdef ARB_ROUND_ROBIN_EN
  logic       r_last_d;
`endif

  assign w_last = (r_cnt == 4'd1);
  assign stall  = (i_req & ~i_ack) | (d_req & ~d_ack);

  // Winner selection is only consulted in IDLE; DONE ignores requests by construction.
  always_comb begin
    w_win = G_NONE;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_req && i_req) begin
      w_win = r_last_d ? G_I : G_D;
    end else if (d_req) begin
      w_win = G_D;
    end else if (i_req) begin
      w_win = G_I;
    end
`else
    if (d_req) begin
      w_win = G_D;
    end else if (i_req) begin
      w_win = G_I;
    end
`endif
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_win != G_NONE) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant <= G_NONE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d <= 1'b1;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win != G_NONE) begin
            r_grant <= w_win;
            m_en    <= 1'b1;
            if (w_win == G_D) begin
              m_addr  <= d_addr;
              m_we    <= d_we;
              r_we    <= d_we;
              m_wdata <= d_wdata;
            end else begin
              m_addr  <= i_addr;
              m_we    <= 1'b0;
              r_we    <= 1'b0;
              m_wdata <= '0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d <= (w_win == G_D);
`endif
          end
        end
        S_ISSUE: begin
          r_cnt <= LAT_INIT;
          m_en  <= 1'b0;
          m_we  <= 1'b0;
        end
        S_WAIT: begin
          if (w_last) begin
            if (r_grant == G_I) begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end else begin
              if (!r_we) d_rdata <= m_rdata;
              d_ack <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_grant <= G_NONE;
          r_cnt   <= '0;
        end
        default: r_grant <= G_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level arbitration model plus a latency-exact RAM model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          i_ack, d_ack, m_en, m_we, stall;
  logic [AW-1:0] m_addr;

  always #5 clock = ~clock;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .stall(stall)
  );

  typedef struct {
    int          port;  // 0 = I, 1 = D
    bit          we;
    logic [31:0] addr, wdata, rdata;
    int          iss_cyc, ack_cyc;
  } txn_t;

  typedef struct {
    int          dly;
    bit          we;
    logic [31:0] addr, wdata;
  } cmd_t;

  int unsigned n_chk = 0, n_fail = 0;
  int          cyc = 0;
  txn_t        iss_q[$], ack_q[$];
  cmd_t        cmd_i[$], cmd_d[$];
  bit          busy[2];
  bit          abort = 1'b0, mon_en = 1'b0;
  logic [31:0] ram[256], ref_mem[256];
  logic [31:0] exp_i_rd = '0, exp_d_rd = '0;
  int          free_cyc = 0, pend_cyc = -1;
  logic [31:0] pend_d = '0;
  bit          last_d = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event, required none (cycle %0d)", nm, cyc);
  endfunction

  function automatic cmd_t mk(input int dly, input bit we, input logic [31:0] a, input logic [31:0] w);
    cmd_t c;
    c.dly = dly; c.we = we; c.addr = a; c.wdata = w;
    return c;
  endfunction

  // Monitor first, then reference model, then RAM model: one ordered process per negedge.
  always @(negedge clock) begin
    txn_t e, t;
    bit   ex_ai, ex_ad, wd;
    ex_ai = 1'b0; ex_ad = 1'b0;
    if (ack_q.size() != 0 && ack_q[0].ack_cyc == cyc) begin
      ex_ai = (ack_q[0].port == 0);
      ex_ad = (ack_q[0].port == 1);
    end
    if (mon_en) begin
      if (m_en) begin
        if (iss_q.size() == 0) bad("unexpected_m_en");
        else begin
          e = iss_q.pop_front();
          chk("issue_cycle", 32'(cyc), 32'(e.iss_cyc));
          chk("m_addr", m_addr, e.addr);
          chk("m_we", 32'(m_we), 32'(e.we));
          if (e.we) chk("m_wdata", m_wdata, e.wdata);
        end
      end
      chk("m_we_outside_issue", 32'(m_we & ~m_en), 32'd0);
      chk("dual_ack", 32'(i_ack & d_ack), 32'd0);
      if (i_ack || d_ack) begin
        if (ack_q.size() == 0) bad("unexpected_ack");
        else begin
          e = ack_q.pop_front();
          chk("ack_port", 32'(d_ack), 32'(e.port));
          chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          if (e.port == 0) exp_i_rd = e.rdata;
          else if (!e.we) exp_d_rd = e.rdata;
        end
      end else if (ack_q.size() != 0 && ack_q[0].ack_cyc < cyc) begin
        e = ack_q.pop_front();
        chk("missing_ack_at_cycle", 32'(cyc), 32'(e.ack_cyc));
      end
      chk("i_rdata", i_rdata, exp_i_rd);
      chk("d_rdata", d_rdata, exp_d_rd);
      chk("stall", 32'(stall), 32'((i_req & ~ex_ai) | (d_req & ~ex_ad)));
    end

    if (reset) begin
      ack_q.delete(); iss_q.delete();
      free_cyc = cyc + 1;
      exp_i_rd = '0; exp_d_rd = '0;
      last_d   = 1'b1;
    end else if (cyc >= free_cyc && (i_req || d_req)) begin
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        wd = !last_d;
`else
        wd = 1'b1;
`endif
      end else wd = d_req;
      t.port = wd ? 1 : 0;
      t.we    = wd ? d_we : 1'b0;
      t.addr  = wd ? d_addr : i_addr;
      t.wdata = wd ? d_wdata : 32'd0;
      t.rdata = ref_mem[t.addr[7:0]];
      if (t.we) ref_mem[t.addr[7:0]] = t.wdata;
      t.iss_cyc = cyc + 1;
      t.ack_cyc = cyc + LAT + 2;
      iss_q.push_back(t);
      ack_q.push_back(t);
      free_cyc = cyc + LAT + 3;
      last_d   = wd;
    end

    if (m_en) begin
      if (m_we) ram[m_addr[7:0]] = m_wdata;
      else begin
        pend_cyc = cyc + LAT;
        pend_d   = ram[m_addr[7:0]];
      end
    end
    m_rdata = (pend_cyc == cyc) ? pend_d : $urandom;
  end

  task automatic drive(input int p);
    cmd_t c;
    bit   got;
    forever begin
      @(posedge clock); #1;
      if ((p == 0 && cmd_i.size() != 0) || (p == 1 && cmd_d.size() != 0)) begin
        if (p == 0) c = cmd_i.pop_front();
        else        c = cmd_d.pop_front();
        busy[p] = 1'b1;
        repeat (c.dly) begin @(posedge clock); #1; end
        if (p == 0) begin
          i_addr = c.addr; i_req = 1'b1;
        end else begin
          d_we = c.we; d_addr = c.addr; d_wdata = c.wdata; d_req = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 60 && !got && !abort; k++) begin
          @(posedge clock); #1;
          got = (p == 0) ? i_ack : d_ack;
        end
        if (!abort) chk(p == 0 ? "i_ack_timeout" : "d_ack_timeout", 32'(got), 32'd1);
        if (p == 0) begin
          i_req = 1'b0; i_addr = $urandom;
        end else begin
          d_req = 1'b0; d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom;
        end
        busy[p] = 1'b0;
      end
    end
  endtask

  initial drive(0);
  initial drive(1);

  task automatic drain();
    for (int k = 0; k < 6000; k++) begin
      @(negedge clock);
      if (cmd_i.size() == 0 && cmd_d.size() == 0 && !busy[0] && !busy[1] && ack_q.size() == 0) return;
    end
    n_chk++; n_fail++;
    $display("FAIL drain_timeout: got busy, required idle (cycle %0d)", cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[16] = 32'h2001000A;
    ref_mem[16] = 32'h2001000A;

    repeat (3) @(negedge clock);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_i_ack", 32'(i_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clock); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    @(negedge clock);
    cmd_i.push_back(mk(0, 1'b0, 32'h10, 32'h0));
    drain();

    @(negedge clock);
    cmd_d.push_back(mk(0, 1'b1, 32'h40, 32'hDEADBEEF));
    cmd_d.push_back(mk(0, 1'b0, 32'h40, 32'h0));
    drain();

    repeat (2) begin
      @(negedge clock);
      cmd_i.push_back(mk(0, 1'b0, 32'h20, 32'h0));
      cmd_d.push_back(mk(0, 1'b0, 32'h24, 32'h0));
      drain();
    end

    @(negedge clock);
    for (int k = 0; k < 40; k++) begin
      cmd_i.push_back(mk($urandom_range(0, 3), 1'b0, $urandom, 32'h0));
      cmd_d.push_back(mk($urandom_range(0, 3), 1'($urandom), $urandom, $urandom));
    end
    drain();

    // Reset while a load sits in WAIT; nothing may be acked for it.
    @(negedge clock);
    cmd_d.push_back(mk(0, 1'b0, 32'h10, 32'h0));
    for (int k = 0; k < 20 && !d_req; k++) @(negedge clock);
    @(posedge clock);
    @(posedge clock); #1;
    abort = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rst_mid_m_en", 32'(m_en), 32'd0);
    chk("rst_mid_d_ack", 32'(d_ack), 32'd0);
    chk("rst_mid_d_rdata", d_rdata, 32'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    abort = 1'b0;
    drain();

    @(negedge clock);
    cmd_d.push_back(mk(0, 1'b0, 32'h40, 32'h0));
    cmd_i.push_back(mk(1, 1'b0, 32'h10, 32'h0));
    drain();
    chk("scoreboard_empty", 32'(ack_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
